// File: rtl/clave_hit_judge_if.sv
// Bundles the round-control inputs and the judging outputs of clave_hit_judge.
// The master side (the counter/button front-end) drives go, count and tap.
interface clave_hit_judge_if;
    logic        go;
    logic [12:0] count;
    logic        tap;
    logic [7:0]  score;
    logic [3:0]  misses;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [2:0]  idx;
    logic        done;

    modport master (
        output go, count, tap,
        input  score, misses, hit_pulse, miss_pulse, idx, done
    );

    modport slave (
        input  go, count, tap,
        output score, misses, hit_pulse, miss_pulse, idx, done
    );
endinterface

// File: rtl/clave_hit_judge.sv
// Classifies player taps against the 3-2 son clave pattern and keeps
// saturating hit/miss tallies for one round started by go.
module clave_hit_judge #(
    parameter logic [12:0] HIT0   = 13'd0,
    parameter logic [12:0] HIT1   = 13'd1200,
    parameter logic [12:0] HIT2   = 13'd2400,
    parameter logic [12:0] HIT3   = 13'd4000,
    parameter logic [12:0] HIT4   = 13'd4800,
    parameter logic [12:0] WINDOW = 13'd150
) (
    input  logic              clk,
    input  logic              resetn,
    clave_hit_judge_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [13:0] WIN_W = {1'b0, WINDOW};

    state_t      state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  misses_q, misses_d;
    logic [2:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic        tap_q, tap_d;

    logic [12:0] target;
    logic [13:0] target_w, lo, hi, cnt_w;
    logic        press, early, late, in_win, advance;

    // Window bounds are widened to 14 bits so hi cannot wrap and lo clamps at 0.
    always_comb begin
        case (idx_q)
            3'd0:    target = HIT0;
            3'd1:    target = HIT1;
            3'd2:    target = HIT2;
            3'd3:    target = HIT3;
            default: target = HIT4;
        endcase
        target_w = {1'b0, target};
        lo       = (target_w >= WIN_W) ? (target_w - WIN_W) : 14'd0;
        hi       = target_w + WIN_W;
        cnt_w    = {1'b0, bus.count};
        early    = cnt_w < lo;
        late     = cnt_w > hi;
        in_win   = !early && !late;
        press    = bus.tap & ~tap_q;
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        misses_d     = misses_q;
        idx_d        = idx_q;
        done_d       = done_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        tap_d        = bus.tap;
        advance      = 1'b0;

        if (bus.go) begin
            state_d  = S_WAIT;
            score_d  = 8'd0;
            misses_d = 4'd0;
            idx_d    = 3'd0;
            done_d   = 1'b0;
        end else if (state_q == S_WAIT) begin
            if (press && in_win) begin
                if (score_q != 8'hFF) score_d = score_q + 8'd1;
                hit_pulse_d = 1'b1;
                advance     = 1'b1;
            end else if (late) begin
                // A press coinciding with a late miss is absorbed into it.
                if (misses_q != 4'hF) misses_d = misses_q + 4'd1;
                miss_pulse_d = 1'b1;
                advance      = 1'b1;
            end else if (press && early) begin
                if (misses_q != 4'hF) misses_d = misses_q + 4'd1;
                miss_pulse_d = 1'b1;
            end

            if (advance) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd4) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            score_q      <= 8'd0;
            misses_q     <= 4'd0;
            idx_q        <= 3'd0;
            done_q       <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            tap_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            idx_q        <= idx_d;
            done_q       <= done_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            tap_q        <= tap_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.misses     = misses_q;
    assign bus.idx        = idx_q;
    assign bus.done       = done_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
endmodule

// File: tb/tb_clave_hit_judge.sv
// Directed bench for clave_hit_judge: count and tap are driven cycle by cycle
// and outputs are sampled 1 time unit after each rising edge.
module tb_clave_hit_judge;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    clave_hit_judge_if bus();

    clave_hit_judge dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic tick(input logic g, input int c, input logic t);
        bus.go    = g;
        bus.count = 13'(c);
        bus.tap   = t;
        @(posedge clk);
        #1;
    endtask

    // go, then an accepted tap on HIT0 at count 0, then release.
    task automatic start_round();
        tick(1'b1, 0, 1'b0);
        tick(1'b0, 0, 1'b1);
        tick(1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(1'b0, 0, 1'b0);
        tick(1'b0, 0, 1'b0);
        checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", bus.score); end
        checks++; if (bus.misses !== 4'd0) begin errors++; $display("FAIL reset_misses: got %0d expected 0", bus.misses); end
        checks++; if (bus.idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", bus.idx); end
        checks++; if ({bus.done, bus.hit_pulse, bus.miss_pulse} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.done, bus.hit_pulse, bus.miss_pulse}); end
        resetn = 1'b1;
        tick(1'b0, 0, 1'b1);
        checks++; if ({bus.hit_pulse, bus.miss_pulse, bus.idx} !== 5'b0) begin errors++; $display("FAIL idle_tap_ignored: got %b expected 00000", {bus.hit_pulse, bus.miss_pulse, bus.idx}); end
        tick(1'b0, 0, 1'b0);
        $display("test_reset done");
    endtask

    task automatic test_clean_round();
        int hits[5] = '{0, 1200, 2400, 4000, 4800};
        tick(1'b1, 0, 1'b0);
        checks++; if (bus.idx !== 3'd0 || bus.score !== 8'd0) begin errors++; $display("FAIL go_clear: got idx=%0d score=%0d expected 0/0", bus.idx, bus.score); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, hits[i], 1'b1);
            checks++; if (bus.hit_pulse !== 1'b1 || bus.score !== 8'(i + 1)) begin errors++; $display("FAIL clean_hit%0d: got pulse=%b score=%0d expected 1/%0d", i, bus.hit_pulse, bus.score, i + 1); end
            tick(1'b0, hits[i], 1'b0);
            checks++; if (bus.hit_pulse !== 1'b0) begin errors++; $display("FAIL clean_pulse_width%0d: got %b expected 0", i, bus.hit_pulse); end
            $display("tap at count %0d -> score %0d idx %0d", hits[i], bus.score, bus.idx);
        end
        checks++; if (bus.done !== 1'b1 || bus.idx !== 3'd5 || bus.misses !== 4'd0) begin errors++; $display("FAIL clean_final: got done=%b idx=%0d misses=%0d expected 1/5/0", bus.done, bus.idx, bus.misses); end
        tick(1'b0, 5000, 1'b1);
        tick(1'b0, 6500, 1'b0);
        checks++; if (bus.score !== 8'd5 || bus.misses !== 4'd0 || bus.done !== 1'b1) begin errors++; $display("FAIL done_ignores_tap: got score=%0d misses=%0d done=%b expected 5/0/1", bus.score, bus.misses, bus.done); end
    endtask

    task automatic test_window_edges();
        start_round();
        tick(1'b0, 1050, 1'b1);
        checks++; if (bus.hit_pulse !== 1'b1 || bus.idx !== 3'd2) begin errors++; $display("FAIL lo_edge_hit: got pulse=%b idx=%0d expected 1/2", bus.hit_pulse, bus.idx); end
        tick(1'b0, 1050, 1'b0);
        $display("window lo 1050 -> idx %0d", bus.idx);

        start_round();
        tick(1'b0, 1049, 1'b1);
        checks++; if (bus.miss_pulse !== 1'b1 || bus.idx !== 3'd1 || bus.misses !== 4'd1) begin errors++; $display("FAIL early_miss: got pulse=%b idx=%0d misses=%0d expected 1/1/1", bus.miss_pulse, bus.idx, bus.misses); end
        tick(1'b0, 1049, 1'b0);
        tick(1'b0, 1350, 1'b1);
        checks++; if (bus.hit_pulse !== 1'b1 || bus.idx !== 3'd2 || bus.score !== 8'd2) begin errors++; $display("FAIL hi_edge_hit: got pulse=%b idx=%0d score=%0d expected 1/2/2", bus.hit_pulse, bus.idx, bus.score); end
        tick(1'b0, 1350, 1'b0);
        $display("window 1049 early, 1350 hit -> score %0d misses %0d", bus.score, bus.misses);

        start_round();
        tick(1'b0, 1350, 1'b0);
        checks++; if (bus.miss_pulse !== 1'b0 || bus.idx !== 3'd1) begin errors++; $display("FAIL no_late_at_hi: got pulse=%b idx=%0d expected 0/1", bus.miss_pulse, bus.idx); end
        tick(1'b0, 1351, 1'b0);
        checks++; if (bus.miss_pulse !== 1'b1 || bus.idx !== 3'd2) begin errors++; $display("FAIL late_miss: got pulse=%b idx=%0d expected 1/2", bus.miss_pulse, bus.idx); end
        tick(1'b0, 1351, 1'b0);
        checks++; if (bus.miss_pulse !== 1'b0 || bus.misses !== 4'd1) begin errors++; $display("FAIL late_single: got pulse=%b misses=%0d expected 0/1", bus.miss_pulse, bus.misses); end
        $display("late at 1351 -> idx %0d", bus.idx);
    endtask

    task automatic test_no_taps();
        int exp_at[5] = '{151, 1351, 2551, 4151, 4951};
        int seen[5] = '{-1, -1, -1, -1, -1};
        int nm = 0;
        tick(1'b1, 0, 1'b0);
        for (int c = 0; c <= 6600; c++) begin
            tick(1'b0, c, 1'b0);
            if (bus.miss_pulse === 1'b1) begin
                if (nm < 5) seen[nm] = c;
                nm++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (seen[i] != exp_at[i]) begin errors++; $display("FAIL late_count%0d: got %0d expected %0d", i, seen[i], exp_at[i]); end
        end
        checks++; if (nm != 5) begin errors++; $display("FAIL late_pulses: got %0d expected 5", nm); end
        checks++; if (bus.misses !== 4'd5 || bus.score !== 8'd0 || bus.done !== 1'b1) begin errors++; $display("FAIL no_tap_final: got misses=%0d score=%0d done=%b expected 5/0/1", bus.misses, bus.score, bus.done); end
        $display("no taps -> misses %0d done %b", bus.misses, bus.done);
    endtask

    task automatic test_held_tap();
        int nh = 0;
        int nmiss = 0;
        int first_hit = -1;
        start_round();
        for (int c = 1190; c <= 1400; c++) begin
            tick(1'b0, c, 1'b1);
            if (bus.hit_pulse === 1'b1) begin
                if (first_hit < 0) first_hit = c;
                nh++;
            end
            if (bus.miss_pulse === 1'b1) nmiss++;
        end
        tick(1'b0, 1400, 1'b0);
        checks++; if (nh != 1 || first_hit != 1190) begin errors++; $display("FAIL held_hits: got %0d at %0d expected 1 at 1190", nh, first_hit); end
        checks++; if (nmiss != 0 || bus.idx !== 3'd2) begin errors++; $display("FAIL held_misses: got misses=%0d idx=%0d expected 0/2", nmiss, bus.idx); end
        $display("held tap 1190..1400 -> hits %0d misses %0d", nh, nmiss);
    endtask

    task automatic test_go_mid_round();
        start_round();
        tick(1'b0, 1200, 1'b1);
        tick(1'b0, 2500, 1'b0);
        checks++; if (bus.score !== 8'd2) begin errors++; $display("FAIL pre_go_score: got %0d expected 2", bus.score); end
        tick(1'b1, 2500, 1'b0);
        checks++; if (bus.score !== 8'd0 || bus.idx !== 3'd0 || bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL go_mid_round: got score=%0d idx=%0d pulses=%b%b expected 0/0/00", bus.score, bus.idx, bus.hit_pulse, bus.miss_pulse); end
        tick(1'b0, 0, 1'b1);
        checks++; if (bus.hit_pulse !== 1'b1 || bus.score !== 8'd1) begin errors++; $display("FAIL go_enters_wait: got pulse=%b score=%0d expected 1/1", bus.hit_pulse, bus.score); end
        tick(1'b0, 0, 1'b0);
        resetn = 1'b0;
        tick(1'b0, 0, 1'b0);
        checks++; if (bus.score !== 8'd0 || bus.idx !== 3'd0 || bus.misses !== 4'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_reset: got score=%0d idx=%0d misses=%0d done=%b expected 0/0/0/0", bus.score, bus.idx, bus.misses, bus.done); end
        resetn = 1'b1;
        tick(1'b0, 0, 1'b1);
        tick(1'b0, 1000, 1'b0);
        checks++; if (bus.score !== 8'd0 || bus.misses !== 4'd0 || bus.idx !== 3'd0) begin errors++; $display("FAIL post_reset_idle: got score=%0d misses=%0d idx=%0d expected 0/0/0", bus.score, bus.misses, bus.idx); end
        $display("go at 2500 and mid-round reset -> score %0d", bus.score);
    endtask

    task automatic test_saturation();
        int exp_m;
        start_round();
        for (int k = 1; k <= 16; k++) begin
            exp_m = (k > 15) ? 15 : k;
            tick(1'b0, 500, 1'b1);
            checks++; if (bus.miss_pulse !== 1'b1 || bus.misses !== 4'(exp_m)) begin errors++; $display("FAIL sat_tap%0d: got pulse=%b misses=%0d expected 1/%0d", k, bus.miss_pulse, bus.misses, exp_m); end
            tick(1'b0, 500, 1'b0);
        end
        checks++; if (bus.idx !== 3'd1 || bus.score !== 8'd1) begin errors++; $display("FAIL sat_idx: got idx=%0d score=%0d expected 1/1", bus.idx, bus.score); end
        $display("16 stray taps -> misses %0d", bus.misses);
    endtask

    initial begin
        resetn    = 1'b0;
        bus.go    = 1'b0;
        bus.count = 13'd0;
        bus.tap   = 1'b0;
        test_reset();
        test_clean_round();
        test_window_edges();
        test_no_taps();
        test_held_tap();
        test_go_mid_round();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
